// File: rtl/npc_pkg.sv
// Shared definitions for the NPC multi-cycle sequencer: state encoding,
// trap codes and the default reset PC.
package npc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_FETCH_REQ  = 4'd1,
        ST_FETCH_WAIT = 4'd2,
        ST_EXEC       = 4'd3,
        ST_MEM_REQ    = 4'd4,
        ST_MEM_WAIT   = 4'd5,
        ST_WB         = 4'd6,
        ST_HALT       = 4'd7,
        ST_ERROR      = 4'd8
    } npc_state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_BUS   = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_ALIGN = 2'b11;

    localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/bus_wait_timer.sv
// Cycle counter for the bus wait states. Cleared when a request is accepted,
// counts every waiting cycle without a response, and flags the cycle on which
// the TMO_CYC-th such cycle is reached.
module bus_wait_timer #(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [15:0] LAST_CNT = 16'(TMO_CYC - 1);

    logic [15:0] r_cnt;

    // Count idle wait cycles, saturating at the last value so it never wraps.
    // NOTE: reset is sampled on the clock edge, and every state register is
    // written with <= so all flops update together at the edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST_CNT)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Expiry is qualified by i_en, so a response in the same cycle wins.
    assign o_expired = i_en && (r_cnt == LAST_CNT);

endmodule

// File: rtl/npc_core_seq.sv
// Multi-cycle sequencer for the NPC core: owns the PC, fetches over a
// valid/ready bus, holds the fetched instruction for decode/execute, stalls
// loads/stores on the LSU handshake, and halts or traps.
module npc_core_seq
    import npc_pkg::*;
#(
    parameter int unsigned          DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0]  RESET_PC = DATA_LEN'(NPC_RESET_PC),
    parameter int unsigned          TMO_CYC  = 255,
    parameter int unsigned          CNT_W    = 32
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    output logic                if_req_valid,
    input  logic                if_req_ready,
    output logic [DATA_LEN-1:0] if_addr,
    input  logic                if_rsp_valid,
    input  logic [DATA_LEN-1:0] if_rsp_data,
    input  logic                if_rsp_err,
    output logic [DATA_LEN-1:0] inst_fetch,
    output logic [DATA_LEN-1:0] PC_now,
    output logic [DATA_LEN-1:0] PC_S,
    input  logic                dec_wen,
    input  logic                dec_is_load,
    input  logic                dec_is_store,
    input  logic                dec_ebreak,
    input  logic                Jump_flag,
    input  logic [DATA_LEN-1:0] Jump_PC,
    output logic                lsu_req_valid,
    input  logic                lsu_req_ready,
    input  logic                lsu_rsp_valid,
    input  logic                lsu_rsp_err,
    output logic                dest_wen,
    output logic                retire_pulse,
    output logic [CNT_W-1:0]    retire_cnt,
    output logic                halted,
    output logic                err,
    output logic [1:0]          err_code
);

    npc_state_e          r_state;
    logic [DATA_LEN-1:0] r_pc;
    logic [DATA_LEN-1:0] r_inst;
    logic [CNT_W-1:0]    r_retire_cnt;
    logic                r_halted;
    logic                r_err;
    logic [1:0]          r_err_code;

    logic [DATA_LEN-1:0] w_pc_s;
    logic [DATA_LEN-1:0] w_next_pc;
    logic                w_misaligned;
    logic                w_is_mem;
    logic                w_exec_commit;
    logic                w_wb;
    logic                w_retire;
    logic                w_tmr_clear;
    logic                w_tmr_en;
    logic                w_tmr_expired;

    assign w_pc_s       = r_pc + DATA_LEN'(4);
    assign w_next_pc    = Jump_flag ? Jump_PC : w_pc_s;
    assign w_misaligned = (w_next_pc[1:0] != 2'b00);
    assign w_is_mem     = dec_is_load || dec_is_store;

    // Commit strobes are decoded from the state register and the live decode
    // inputs so the regfile write lands while PC_now still names this
    // instruction (link values such as PC_S depend on it).
    assign w_exec_commit = (r_state == ST_EXEC) && !dec_ebreak && !w_misaligned && !w_is_mem;
    assign w_wb          = (r_state == ST_WB);
    assign w_retire      = ((r_state == ST_EXEC) && dec_ebreak) || w_exec_commit || w_wb;

    // One timer serves both wait states: it restarts on each accept and only
    // counts while a wait state sees no response.
    assign w_tmr_clear = ((r_state == ST_FETCH_REQ) && if_req_ready) ||
                         ((r_state == ST_MEM_REQ)   && lsu_req_ready);
    assign w_tmr_en    = ((r_state == ST_FETCH_WAIT) && !if_rsp_valid) ||
                         ((r_state == ST_MEM_WAIT)   && !lsu_rsp_valid);

    bus_wait_timer #(
        .TMO_CYC (TMO_CYC)
    ) u_wait_timer (
        .i_clk     (sys_clk),
        .i_rst_n   (sys_rst_n),
        .i_clear   (w_tmr_clear),
        .i_en      (w_tmr_en),
        .o_expired (w_tmr_expired)
    );

    // Sequencer FSM: state, PC, instruction latch and sticky status.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_inst     <= '0;
            r_halted   <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_FETCH_REQ;
                ST_FETCH_REQ: begin
                    if (if_req_ready) r_state <= ST_FETCH_WAIT;
                end
                ST_FETCH_WAIT: begin
                    if (if_rsp_valid) begin
                        if (if_rsp_err) begin
                            r_state    <= ST_ERROR;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_BUS;
                        end else begin
                            r_inst  <= if_rsp_data;
                            r_state <= ST_EXEC;
                        end
                    end else if (w_tmr_expired) begin
                        r_state    <= ST_ERROR;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_TMO;
                    end
                end
                ST_EXEC: begin
                    if (dec_ebreak) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (w_misaligned) begin
                        r_state    <= ST_ERROR;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_ALIGN;
                    end else if (w_is_mem) begin
                        r_state <= ST_MEM_REQ;
                    end else begin
                        r_pc    <= w_next_pc;
                        r_state <= ST_FETCH_REQ;
                    end
                end
                ST_MEM_REQ: begin
                    if (lsu_req_ready) r_state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (lsu_rsp_valid) begin
                        if (lsu_rsp_err) begin
                            r_state    <= ST_ERROR;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_BUS;
                        end else begin
                            r_state <= ST_WB;
                        end
                    end else if (w_tmr_expired) begin
                        r_state    <= ST_ERROR;
                        r_err      <= 1'b1;
                        r_err_code <= ERR_TMO;
                    end
                end
                ST_WB: begin
                    r_pc    <= w_pc_s;
                    r_state <= ST_FETCH_REQ;
                end
                ST_HALT:  r_state <= ST_HALT;
                ST_ERROR: r_state <= ST_ERROR;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    // Strobes are gated by reset so nothing is requested or committed while
    // reset is held, even before the first reset edge arrives.
    assign if_req_valid  = sys_rst_n && (r_state == ST_FETCH_REQ);
    assign lsu_req_valid = sys_rst_n && (r_state == ST_MEM_REQ);
    assign dest_wen      = sys_rst_n && ((w_exec_commit && dec_wen) ||
                                         (w_wb && dec_wen && dec_is_load && !dec_is_store));
    assign retire_pulse  = sys_rst_n && w_retire;

    assign if_addr    = r_pc;
    assign PC_now     = r_pc;
    assign PC_S       = w_pc_s;
    assign inst_fetch = r_inst;
    assign retire_cnt = r_retire_cnt;
    assign halted     = r_halted;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_npc_core_seq.sv
// Directed bench for npc_core_seq: fetch/execute timing, redirect, load stall,
// fetch timeout, misaligned target, ebreak halt, reset abandonment, bus error.
module tb_npc_core_seq;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic [31:0] inst_fetch;
    logic [31:0] PC_now;
    logic [31:0] PC_S;
    logic        dec_wen;
    logic        dec_is_load;
    logic        dec_is_store;
    logic        dec_ebreak;
    logic        Jump_flag;
    logic [31:0] Jump_PC;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic        lsu_rsp_err;
    logic        dest_wen;
    logic        retire_pulse;
    logic [31:0] retire_cnt;
    logic        halted;
    logic        err;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_errors = 0;
    int n_steps  = 0;
    int wen_cnt  = 0;

    npc_core_seq #(
        .DATA_LEN (32),
        .RESET_PC (32'h8000_0000),
        .TMO_CYC  (8),
        .CNT_W    (32)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .if_rsp_err    (if_rsp_err),
        .inst_fetch    (inst_fetch),
        .PC_now        (PC_now),
        .PC_S          (PC_S),
        .dec_wen       (dec_wen),
        .dec_is_load   (dec_is_load),
        .dec_is_store  (dec_is_store),
        .dec_ebreak    (dec_ebreak),
        .Jump_flag     (Jump_flag),
        .Jump_PC       (Jump_PC),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_err   (lsu_rsp_err),
        .dest_wen      (dest_wen),
        .retire_pulse  (retire_pulse),
        .retire_cnt    (retire_cnt),
        .halted        (halted),
        .err           (err),
        .err_code      (err_code)
    );

    always #5 sys_clk = ~sys_clk;

    // Count regfile write strobes seen at each active edge since reset.
    always @(posedge sys_clk) begin
        if (!sys_rst_n) wen_cnt <= 0;
        else if (dest_wen) wen_cnt <= wen_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge sys_clk);
        n_steps++;
    endtask

    task automatic clear_decode();
        dec_wen      = 1'b0;
        dec_is_load  = 1'b0;
        dec_is_store = 1'b0;
        dec_ebreak   = 1'b0;
        Jump_flag    = 1'b0;
        Jump_PC      = 32'h0;
    endtask

    task automatic reset_dut();
        sys_rst_n     = 1'b0;
        if_req_ready  = 1'b1;
        if_rsp_valid  = 1'b0;
        if_rsp_data   = 32'h0;
        if_rsp_err    = 1'b0;
        lsu_req_ready = 1'b1;
        lsu_rsp_valid = 1'b0;
        lsu_rsp_err   = 1'b0;
        clear_decode();
        step();
        step();
    endtask

    task automatic wait_if_req(input string tag);
        int n = 0;
        while (!if_req_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_req"}, 32'(if_req_valid), 32'd1);
    endtask

    // Accept a fetch, answer one cycle later, stop at the EXEC cycle.
    task automatic fetch_to_exec(input string tag, input logic [31:0] exp_addr, input logic [31:0] instr);
        wait_if_req(tag);
        check({tag, "_addr"}, if_addr, exp_addr);
        step();
        if_rsp_valid = 1'b1;
        if_rsp_data  = instr;
        step();
        if_rsp_valid = 1'b0;
        check({tag, "_inst"}, inst_fetch, instr);
    endtask

    task automatic run_alu(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                           input logic wen, input logic jf, input logic [31:0] jpc);
        dec_wen   = wen;
        Jump_flag = jf;
        Jump_PC   = jpc;
        fetch_to_exec(tag, addr, instr);
        check({tag, "_wen"}, 32'(dest_wen), 32'(wen));
        check({tag, "_ret"}, 32'(retire_pulse), 32'd1);
        step();
        clear_decode();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int t0;

        // 1: reset values, then three ALU instructions at 3 cycles each
        reset_dut();
        check("rst_pc",    PC_now, 32'h8000_0000);
        check("rst_cnt",   retire_cnt, 32'd0);
        check("rst_inst",  inst_fetch, 32'd0);
        check("rst_halt",  32'(halted), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_code",  32'(err_code), 32'd0);
        check("rst_ifreq", 32'(if_req_valid), 32'd0);
        check("rst_lsreq", 32'(lsu_req_valid), 32'd0);
        sys_rst_n = 1'b1;
        t0 = n_steps;
        run_alu("t1a", 32'h8000_0000, 32'h0010_0093, 1'b1, 1'b0, 32'h0);
        run_alu("t1b", 32'h8000_0004, 32'h0020_0113, 1'b1, 1'b0, 32'h0);
        run_alu("t1c", 32'h8000_0008, 32'h0030_0193, 1'b1, 1'b0, 32'h0);
        check("t1_cycles", 32'(n_steps - t0), 32'd10);
        check("t1_cnt",    retire_cnt, 32'd3);
        check("t1_pc",     PC_now, 32'h8000_000C);
        check("t1_wens",   32'(wen_cnt), 32'd3);

        // 2: taken redirect from 80000004 to 80000100
        reset_dut();
        sys_rst_n = 1'b1;
        run_alu("t2a", 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        run_alu("t2b", 32'h8000_0004, 32'h0fc0_00ef, 1'b1, 1'b1, 32'h8000_0100);
        check("t2_wens", 32'(wen_cnt), 32'd1);
        wait_if_req("t2n");
        check("t2_addr", if_addr, 32'h8000_0100);
        check("t2_pcs",  PC_S, 32'h8000_0104);

        // 3: load stalled 4 cycles on ready, response in 2nd wait cycle
        reset_dut();
        sys_rst_n   = 1'b1;
        dec_is_load = 1'b1;
        dec_wen     = 1'b1;
        fetch_to_exec("t3", 32'h8000_0000, 32'h0000_2083);
        check("t3_exec_wen", 32'(dest_wen), 32'd0);
        check("t3_exec_ret", 32'(retire_pulse), 32'd0);
        lsu_req_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("t3_hold", 32'(lsu_req_valid), 32'd1);
            step();
        end
        lsu_req_ready = 1'b1;
        lsu_rsp_valid = 1'b1;
        check("t3_acc_valid", 32'(lsu_req_valid), 32'd1);
        step();
        lsu_rsp_valid = 1'b0;
        check("t3_w1_req", 32'(lsu_req_valid), 32'd0);
        check("t3_w1_wen", 32'(dest_wen), 32'd0);
        step();
        lsu_rsp_valid = 1'b1;
        check("t3_w2_wen", 32'(dest_wen), 32'd0);
        step();
        lsu_rsp_valid = 1'b0;
        check("t3_wb_wen", 32'(dest_wen), 32'd1);
        check("t3_wb_ret", 32'(retire_pulse), 32'd1);
        step();
        check("t3_pc",   PC_now, 32'h8000_0004);
        check("t3_cnt",  retire_cnt, 32'd1);
        check("t3_wens", 32'(wen_cnt), 32'd1);
        clear_decode();

        // 4: fetch response never arrives, timeout after 8 wait cycles
        reset_dut();
        sys_rst_n = 1'b1;
        wait_if_req("t4");
        step();
        for (int i = 1; i < 8; i++) step();
        check("t4_err_pre", 32'(err), 32'd0);
        step();
        check("t4_err",  32'(err), 32'd1);
        check("t4_code", 32'(err_code), 32'd2);
        check("t4_req0", 32'(if_req_valid), 32'd0);
        step();
        step();
        check("t4_req1", 32'(if_req_valid), 32'd0);
        check("t4_pc",   PC_now, 32'h8000_0000);

        // 5: misaligned redirect target traps without retiring
        reset_dut();
        sys_rst_n = 1'b1;
        dec_wen   = 1'b1;
        Jump_flag = 1'b1;
        Jump_PC   = 32'h8000_0102;
        fetch_to_exec("t5", 32'h8000_0000, 32'h1000_006f);
        check("t5_wen", 32'(dest_wen), 32'd0);
        check("t5_ret", 32'(retire_pulse), 32'd0);
        step();
        clear_decode();
        check("t5_err",  32'(err), 32'd1);
        check("t5_code", 32'(err_code), 32'd3);
        check("t5_cnt",  retire_cnt, 32'd0);
        check("t5_pc",   PC_now, 32'h8000_0000);
        check("t5_wens", 32'(wen_cnt), 32'd0);

        // 6: ebreak at 80000010 halts with the PC frozen
        reset_dut();
        sys_rst_n = 1'b1;
        run_alu("t6a", 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        run_alu("t6b", 32'h8000_0004, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        run_alu("t6c", 32'h8000_0008, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        run_alu("t6d", 32'h8000_000C, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        dec_ebreak = 1'b1;
        fetch_to_exec("t6e", 32'h8000_0010, 32'h0010_0073);
        check("t6_ret", 32'(retire_pulse), 32'd1);
        check("t6_wen", 32'(dest_wen), 32'd0);
        step();
        check("t6_halt", 32'(halted), 32'd1);
        check("t6_cnt",  retire_cnt, 32'd5);
        check("t6_pc",   PC_now, 32'h8000_0010);
        check("t6_err",  32'(err), 32'd0);
        step();
        check("t6_req", 32'(if_req_valid), 32'd0);
        clear_decode();

        // 6b: reset during FETCH_WAIT, late response must be ignored
        reset_dut();
        sys_rst_n = 1'b1;
        wait_if_req("t6r");
        step();
        sys_rst_n    = 1'b0;
        if_req_ready = 1'b0;
        step();
        sys_rst_n    = 1'b1;
        if_rsp_valid = 1'b1;
        if_rsp_data  = 32'hDEAD_BEEF;
        step();
        check("t6r_req", 32'(if_req_valid), 32'd1);
        step();
        check("t6r_inst", inst_fetch, 32'd0);
        check("t6r_addr", if_addr, 32'h8000_0000);
        check("t6r_err",  32'(err), 32'd0);
        if_rsp_valid = 1'b0;
        if_req_ready = 1'b1;

        // 7: fetch bus error traps with code 01
        reset_dut();
        sys_rst_n = 1'b1;
        wait_if_req("t7");
        step();
        if_rsp_valid = 1'b1;
        if_rsp_err   = 1'b1;
        if_rsp_data  = 32'h1234_5678;
        step();
        if_rsp_valid = 1'b0;
        if_rsp_err   = 1'b0;
        check("t7_err",  32'(err), 32'd1);
        check("t7_code", 32'(err_code), 32'd1);
        check("t7_inst", inst_fetch, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
